// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared gshare predictor types and sizes
// Purpose: index/counter widths shared with the branch history stage, the
//          2-bit counter encodings and the pattern table FSM states.
// Ports:   none (package).
package bp_pkg;

   localparam int INDEX_W = 6;
   localparam int CTR_W   = 2;

   typedef enum logic [CTR_W-1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/pattern_counter_table_if.sv
// rtl/pattern_counter_table_if.sv - lookup/update/status bundle of the pattern table
// Purpose: groups the fetch-side lookup, the EX-side update and the status
//          outputs of pattern_counter_table.
// Ports:   none; signals
//          pred_valid/pred_index        lookup request (master -> table)
//          pred_out_valid/pred_taken    lookup result  (table -> master)
//          upd_valid/upd_index/upd_taken/upd_predicted  resolved update
//          ready, update_count, mispredict_count         status
//          modport master = requester side, slave = table side.
interface pattern_counter_table_if #(
   parameter int INDEX_W = bp_pkg::INDEX_W,
   parameter int STAT_W  = 16
) ();

   logic               pred_valid;
   logic [INDEX_W-1:0] pred_index;
   logic               pred_out_valid;
   logic               pred_taken;
   logic               upd_valid;
   logic [INDEX_W-1:0] upd_index;
   logic               upd_taken;
   logic               upd_predicted;
   logic               ready;
   logic [STAT_W-1:0]  update_count;
   logic [STAT_W-1:0]  mispredict_count;

   modport master (
      output pred_valid, pred_index, upd_valid, upd_index, upd_taken, upd_predicted,
      input  pred_out_valid, pred_taken, ready, update_count, mispredict_count
   );

   modport slave (
      input  pred_valid, pred_index, upd_valid, upd_index, upd_taken, upd_predicted,
      output pred_out_valid, pred_taken, ready, update_count, mispredict_count
   );

endinterface

// File: rtl/pattern_counter_table_sat_counter_next.sv
// rtl/pattern_counter_table_sat_counter_next.sv - 2-bit saturating counter step
// Purpose: combinational next value of a saturating counter given the
//          resolved direction; shared by the table write path and the bypass.
// Ports:   ctr      in   current counter value
//          taken    in   resolved outcome (1 = count up)
//          ctr_next out  saturated next value (never wraps)
module sat_counter_next #(
   parameter int CTR_W = bp_pkg::CTR_W
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             taken,
   output logic [CTR_W-1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (taken && (ctr != '1)) begin
         ctr_next = ctr + 1'b1;
      end else if (!taken && (ctr != '0)) begin
         ctr_next = ctr - 1'b1;
      end
   end

endmodule

// File: rtl/pattern_counter_table.sv
// rtl/pattern_counter_table.sv - gshare pattern history table of saturating counters
// Purpose: 2**INDEX_W saturating counters. After reset the table walks every
//          entry writing INIT_VALUE (INIT), then serves lookups with one cycle
//          latency and applies resolved-branch updates (RUN). A same-cycle
//          update to the looked-up entry is bypassed into the prediction.
//          Update and mispredict totals saturate.
// Ports:   clk    in   clock, all state on posedge
//          reset  in   asynchronous, active-low
//          bus    slave modport of pattern_counter_table_if
module pattern_counter_table #(
   parameter int               INDEX_W    = bp_pkg::INDEX_W,
   parameter int               CTR_W      = bp_pkg::CTR_W,
   parameter logic [CTR_W-1:0] INIT_VALUE = bp_pkg::WNT,
   parameter int               STAT_W     = 16
) (
   input logic                    clk,
   input logic                    reset,
   pattern_counter_table_if.slave bus
);

   import bp_pkg::*;

   localparam int                 DEPTH    = 1 << INDEX_W;
   localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

   state_e             state;
   state_e             state_nx;
   logic [INDEX_W-1:0] init_ptr;
   logic [INDEX_W-1:0] init_ptr_nx;

   // Not reset: INIT rewrites every entry after each reset.
   logic [CTR_W-1:0]   table_q [DEPTH];

   logic               run;
   logic               upd_en;
   logic               pred_en;
   logic               mispredict;
   logic [CTR_W-1:0]   upd_cur;
   logic [CTR_W-1:0]   upd_next;
   logic [CTR_W-1:0]   rd_ctr;

   logic               pred_out_valid_q;
   logic               pred_taken_q;
   logic [STAT_W-1:0]  update_count_q;
   logic [STAT_W-1:0]  mispredict_count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= INIT;
         init_ptr <= '0;
      end else begin
         state    <= state_nx;
         init_ptr <= init_ptr_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      init_ptr_nx = init_ptr;
      case (state)
         INIT: begin
            init_ptr_nx = init_ptr + 1'b1;
            if (init_ptr == LAST_IDX) begin
               state_nx = RUN;
            end
         end
         RUN:     state_nx = RUN;
         default: state_nx = INIT;
      endcase
   end

   assign run        = (state == RUN);
   assign upd_en     = run && bus.upd_valid;
   assign pred_en    = run && bus.pred_valid;
   assign mispredict = (bus.upd_taken != bus.upd_predicted);
   assign upd_cur    = table_q[bus.upd_index];

   sat_counter_next #(.CTR_W(CTR_W)) u_next (
      .ctr      (upd_cur),
      .taken    (bus.upd_taken),
      .ctr_next (upd_next)
   );

   // Same entry updated this cycle: predict from the value being written.
   assign rd_ctr = (upd_en && (bus.upd_index == bus.pred_index)) ? upd_next
                                                                 : table_q[bus.pred_index];

   always_ff @(posedge clk) begin
      if (!run) begin
         table_q[init_ptr] <= INIT_VALUE;
      end else if (upd_en) begin
         table_q[bus.upd_index] <= upd_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pred_out_valid_q   <= 1'b0;
         pred_taken_q       <= 1'b0;
         update_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         pred_out_valid_q <= pred_en;
         if (pred_en) begin
            pred_taken_q <= rd_ctr[CTR_W-1];
         end
         if (upd_en) begin
            if (update_count_q != '1) begin
               update_count_q <= update_count_q + 1'b1;
            end
            if (mispredict && (mispredict_count_q != '1)) begin
               mispredict_count_q <= mispredict_count_q + 1'b1;
            end
         end
      end
   end

   assign bus.ready            = run;
   assign bus.pred_out_valid   = pred_out_valid_q;
   assign bus.pred_taken       = pred_taken_q;
   assign bus.update_count     = update_count_q;
   assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_pattern_counter_table.sv
// tb/tb_pattern_counter_table.sv - self-checking bench for pattern_counter_table
module tb_pattern_counter_table;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   pattern_counter_table_if #(.INDEX_W(6), .STAT_W(16)) bus ();
   pattern_counter_table_if #(.INDEX_W(6), .STAT_W(4))  bus4 ();

   pattern_counter_table #(.INDEX_W(6), .CTR_W(2), .INIT_VALUE(2'b01), .STAT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   pattern_counter_table #(.INDEX_W(6), .CTR_W(2), .INIT_VALUE(2'b01), .STAT_W(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: counters as plain integers clamped to 0..3.
   int m_ctr [64];
   int m_uc;
   int m_mc;
   bit m_ov;
   bit m_pt;
   bit m_run;

   task automatic model_reset();
      m_uc  = 0;
      m_mc  = 0;
      m_ov  = 0;
      m_pt  = 0;
      m_run = 0;
   endtask

   task automatic model_ready();
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_run = 1;
   endtask

   task automatic idle_inputs();
      bus.pred_valid     = 0;
      bus.pred_index     = '0;
      bus.upd_valid      = 0;
      bus.upd_index      = '0;
      bus.upd_taken      = 0;
      bus.upd_predicted  = 0;
      bus4.pred_valid    = 0;
      bus4.pred_index    = '0;
      bus4.upd_valid     = 0;
      bus4.upd_index     = '0;
      bus4.upd_taken     = 0;
      bus4.upd_predicted = 0;
   endtask

   // One clock of stimulus on the main table; returns sampled #1 after the edge.
   task automatic step(input bit pv, input int pi, input bit uv, input int ui,
                       input bit ut, input bit up);
      bus.pred_valid    = pv;
      bus.pred_index    = 6'(pi);
      bus.upd_valid     = uv;
      bus.upd_index     = 6'(ui);
      bus.upd_taken     = ut;
      bus.upd_predicted = up;
      @(posedge clk);
      #1;
      if (m_run) begin
         if (uv) begin
            m_ctr[ui] = ut ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1)
                           : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
            if (m_uc < 65535) m_uc++;
            if (ut != up && m_mc < 65535) m_mc++;
         end
         m_ov = pv;
         if (pv) m_pt = (m_ctr[pi] >= 2);
      end else begin
         m_ov = 0;
      end
      idle_inputs();
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!bus.ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      model_ready();
   endtask

   task automatic test_reset();
      int n;
      idle_inputs();
      model_reset();
      #1 reset = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.pred_out_valid !== 1'b0) begin errors++; $display("FAIL reset_pov got %b want 0", bus.pred_out_valid); end
      checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pt got %b want 0", bus.pred_taken); end
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
      checks++; if (bus.update_count !== 16'd0) begin errors++; $display("FAIL reset_uc got %0d want 0", bus.update_count); end
      checks++; if (bus.mispredict_count !== 16'd0) begin errors++; $display("FAIL reset_mc got %0d want 0", bus.mispredict_count); end
      reset = 1;
      wait_ready(n);
      checks++; if (n != 64) begin errors++; $display("FAIL ready_latency got %0d want 64", n); end
      checks++; if (bus4.ready !== 1'b1) begin errors++; $display("FAIL ready_dut4 got %b want 1", bus4.ready); end
   endtask

   task automatic test_init_lookups();
      int idx [3] = '{0, 31, 63};
      for (int k = 0; k < 3; k++) begin
         step(1, idx[k], 0, 0, 0, 0);
         checks++; if (bus.pred_out_valid !== 1'b1) begin errors++; $display("FAIL init_lookup_pov idx %0d got %b want 1", idx[k], bus.pred_out_valid); end
         checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL init_lookup_pt idx %0d got %b want 0", idx[k], bus.pred_taken); end
         step(0, 0, 0, 0, 0, 0);
         checks++; if (bus.pred_out_valid !== 1'b0) begin errors++; $display("FAIL init_lookup_pulse idx %0d got %b want 0", idx[k], bus.pred_out_valid); end
      end
   endtask

   task automatic test_saturation();
      // taken x4, then not-taken x5, looking up idx 5 after every update
      bit dir [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
      for (int k = 0; k < 9; k++) begin
         step(0, 0, 1, 5, dir[k], dir[k]);
         step(1, 5, 0, 0, 0, 0);
         checks++; if (bus.pred_taken !== m_pt) begin errors++; $display("FAIL sat_idx5 step %0d got %b want %b", k, bus.pred_taken, m_pt); end
      end
      checks++; if (m_ctr[5] != 0 || bus.pred_taken !== 1'b0) begin errors++; $display("FAIL sat_floor got %b want 0", bus.pred_taken); end
   endtask

   task automatic test_bypass();
      step(1, 9, 1, 10, 1, 1);
      checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL indep_idx9 got %b want 0", bus.pred_taken); end
      step(1, 9, 1, 9, 1, 0);
      checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL bypass_idx9 got %b want 1", bus.pred_taken); end
      checks++; if (bus.pred_out_valid !== 1'b1) begin errors++; $display("FAIL bypass_pov got %b want 1", bus.pred_out_valid); end
   endtask

   task automatic test_init_ignore();
      int n;
      #1 reset = 0;
      model_reset();
      @(posedge clk);
      #1 reset = 1;
      for (int k = 0; k < 10; k++) begin
         step(1, 0, 1, 0, 1, 0);
         checks++; if (bus.pred_out_valid !== 1'b0) begin errors++; $display("FAIL init_ignore_pov cycle %0d got %b want 0", k, bus.pred_out_valid); end
      end
      wait_ready(n);
      checks++; if (n != 54) begin errors++; $display("FAIL init_ignore_ready got %0d want 54", n); end
      step(1, 0, 0, 0, 0, 0);
      checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL init_ignore_idx0 got %b want 0", bus.pred_taken); end
      checks++; if (bus.update_count !== 16'd0) begin errors++; $display("FAIL init_ignore_uc got %0d want 0", bus.update_count); end
   endtask

   task automatic test_stats();
      bit ut [5] = '{1, 0, 1, 1, 0};
      bit up [5] = '{0, 0, 0, 1, 1};
      for (int k = 0; k < 5; k++) step(0, 0, 1, 20 + k, ut[k], up[k]);
      checks++; if (bus.update_count !== 16'd5) begin errors++; $display("FAIL stats_uc got %0d want 5", bus.update_count); end
      checks++; if (bus.mispredict_count !== 16'd3) begin errors++; $display("FAIL stats_mc got %0d want 3", bus.mispredict_count); end
   endtask

   task automatic test_stat_saturate();
      int uc4 = 0;
      int mc4 = 0;
      for (int k = 0; k < 20; k++) begin
         bus4.upd_valid     = 1;
         bus4.upd_index     = 6'($urandom_range(0, 63));
         bus4.upd_taken     = 1;
         bus4.upd_predicted = 0;
         @(posedge clk);
         #1;
         uc4 = (uc4 < 15) ? uc4 + 1 : 15;
         mc4 = (mc4 < 15) ? mc4 + 1 : 15;
      end
      idle_inputs();
      checks++; if (bus4.update_count !== 4'(uc4)) begin errors++; $display("FAIL stat4_uc got %0d want %0d", bus4.update_count, uc4); end
      checks++; if (bus4.mispredict_count !== 4'(mc4)) begin errors++; $display("FAIL stat4_mc got %0d want %0d", bus4.mispredict_count, mc4); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
         checks++; if (bus.pred_out_valid !== m_ov) begin errors++; $display("FAIL rand_pov cycle %0d got %b want %b", k, bus.pred_out_valid, m_ov); end
         checks++; if (bus.pred_taken !== m_pt) begin errors++; $display("FAIL rand_pt cycle %0d got %b want %b", k, bus.pred_taken, m_pt); end
         checks++; if (bus.update_count !== 16'(m_uc)) begin errors++; $display("FAIL rand_uc cycle %0d got %0d want %0d", k, bus.update_count, m_uc); end
         checks++; if (bus.mispredict_count !== 16'(m_mc)) begin errors++; $display("FAIL rand_mc cycle %0d got %0d want %0d", k, bus.mispredict_count, m_mc); end
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      step(0, 0, 1, 5, 1, 1);
      step(0, 0, 1, 5, 1, 0);
      step(1, 5, 0, 0, 0, 0);
      checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL midrun_trained got %b want 1", bus.pred_taken); end
      reset = 0;
      model_reset();
      #1;
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL midrun_ready got %b want 0", bus.ready); end
      checks++; if (bus.pred_out_valid !== 1'b0 || bus.pred_taken !== 1'b0) begin errors++; $display("FAIL midrun_pred got %b%b want 00", bus.pred_out_valid, bus.pred_taken); end
      checks++; if (bus.update_count !== 16'd0 || bus.mispredict_count !== 16'd0) begin errors++; $display("FAIL midrun_stats got %0d/%0d want 0/0", bus.update_count, bus.mispredict_count); end
      @(posedge clk);
      #1 reset = 1;
      wait_ready(n);
      checks++; if (n != 64) begin errors++; $display("FAIL midrun_reinit got %0d want 64", n); end
      step(1, 5, 0, 0, 0, 0);
      checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL midrun_idx5 got %b want 0", bus.pred_taken); end
   endtask

   initial begin
      test_reset();
      test_init_lookups();
      test_saturation();
      test_bypass();
      test_random();
      test_init_ignore();
      test_stats();
      test_stat_saturate();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
